dbg_snapshot_tx: RTL and testbench

- UART transmit path of the MU0 debug link: serialises one snapshot of the core's debug state (ir, pc, acc, state, ALU result, ALU op) into a fixed 13-byte frame toward the host.
- Complements the command receiver. The debug controller pulses send, for example after a manual clock step, and the block drives uart_tx until the frame is complete.
- Sits beside the uart debug controller under main and runs on the fast board clock.

---
 rtl/dbg_link_pkg.sv | 38 +++
 rtl/uart_byte_tx.sv | 104 ++++++++++
 rtl/dbg_snapshot_tx.sv | 139 +++++++++++++
 tb/tb_dbg_snapshot_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_link_pkg.sv
// rtl/dbg_link_pkg.sv - shared constants and state types for the MU0 debug link
package dbg_link_pkg;

  // First byte of every snapshot frame; the host resynchronises on it.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 13;

  // Byte positions inside a frame, shared with the host decoder and receiver.
  localparam logic [3:0] IDX_SYNC     = 4'd0;
  localparam logic [3:0] IDX_IR_HI    = 4'd1;
  localparam logic [3:0] IDX_IR_LO    = 4'd2;
  localparam logic [3:0] IDX_PC_HI    = 4'd3;
  localparam logic [3:0] IDX_PC_LO    = 4'd4;
  localparam logic [3:0] IDX_ACC_HI   = 4'd5;
  localparam logic [3:0] IDX_ACC_LO   = 4'd6;
  localparam logic [3:0] IDX_STATE_HI = 4'd7;
  localparam logic [3:0] IDX_STATE_LO = 4'd8;
  localparam logic [3:0] IDX_ALU_HI   = 4'd9;
  localparam logic [3:0] IDX_ALU_LO   = 4'd10;
  localparam logic [3:0] IDX_ALU_OP   = 4'd11;
  localparam logic [3:0] IDX_CHK      = 4'(FRAME_LEN - 1);

  // Frame sequencer; byte loading is folded into the transitions, so it has no state of its own.
  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_WAIT_BYTE,
    SEQ_FINISH
  } seq_state_e;

  // Byte transmitter line states.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 LSB-first byte serialiser with back-to-back restart
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byteDone,
  output logic       busy
);
  import dbg_link_pkg::*;

  localparam int             CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             last;

  assign last     = (cnt_q == CNT_LAST);
  assign byteDone = (state_q == TX_STOP) && last;
  assign busy     = (state_q != TX_IDLE);
  assign tx       = tx_q;

  // Next-state logic; a start seen in the last stop cycle restarts without an idle gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != TX_IDLE) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_START;
          shift_d = data;
          cnt_d   = '0;
          tx_d    = 1'b0;
        end
      end
      TX_START: begin
        if (last) begin
          state_d = TX_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      TX_DATA: begin
        if (last) begin
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (last) begin
          if (start) begin
            state_d = TX_START;
            shift_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; the line idles high out of reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/dbg_snapshot_tx.sv
// rtl/dbg_snapshot_tx.sv - latches a debug snapshot and sends it as a 13-byte UART frame
module dbg_snapshot_tx #(
  parameter int         CLKS_PER_BIT = 234,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        send,
  input  logic [15:0] dbgIr,
  input  logic [15:0] dbgPc,
  input  logic [15:0] dbgAcc,
  input  logic [8:0]  dbgState,
  input  logic [15:0] dbgAluResult,
  input  logic [3:0]  dbgAluOp,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);
  import dbg_link_pkg::*;

  seq_state_e  seq_q, seq_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [15:0] ir_q, pc_q, acc_q, alu_q;
  logic [8:0]  st_q;
  logic [3:0]  op_q;
  logic        accept;
  logic [3:0]  load_idx;
  logic [7:0]  load_byte;
  logic        tx_start;
  logic        byte_done;
  logic        tx_busy;

  // FINISH accepts like IDLE so that a held send yields frames one cycle apart.
  assign accept   = send && ((seq_q == SEQ_IDLE) || (seq_q == SEQ_FINISH));
  assign load_idx = accept ? IDX_SYNC : idx_q + 4'd1;

  // Byte selected for the transmitter at the moment it is handed over.
  always_comb begin
    load_byte = 8'h00;
    case (load_idx)
      IDX_SYNC:     load_byte = SYNC_BYTE;
      IDX_IR_HI:    load_byte = ir_q[15:8];
      IDX_IR_LO:    load_byte = ir_q[7:0];
      IDX_PC_HI:    load_byte = pc_q[15:8];
      IDX_PC_LO:    load_byte = pc_q[7:0];
      IDX_ACC_HI:   load_byte = acc_q[15:8];
      IDX_ACC_LO:   load_byte = acc_q[7:0];
      IDX_STATE_HI: load_byte = {7'b0, st_q[8]};
      IDX_STATE_LO: load_byte = st_q[7:0];
      IDX_ALU_HI:   load_byte = alu_q[15:8];
      IDX_ALU_LO:   load_byte = alu_q[7:0];
      IDX_ALU_OP:   load_byte = {4'b0, op_q};
      IDX_CHK:      load_byte = chk_q;
      default:      load_byte = 8'h00;
    endcase
  end

  // Sequencer next state; each load happens on the byte_done edge so bytes abut.
  always_comb begin
    seq_d    = seq_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    tx_start = 1'b0;
    case (seq_q)
      SEQ_IDLE, SEQ_FINISH: begin
        seq_d = SEQ_IDLE;
        if (send) begin
          seq_d    = SEQ_WAIT_BYTE;
          idx_d    = IDX_SYNC;
          chk_d    = 8'h00;
          tx_start = 1'b1;
        end
      end
      SEQ_WAIT_BYTE: begin
        if (byte_done) begin
          if (idx_q < IDX_CHK) begin
            idx_d    = load_idx;
            tx_start = 1'b1;
            if (load_idx != IDX_CHK) begin
              chk_d = chk_q ^ load_byte;
            end
          end else begin
            seq_d = SEQ_FINISH;
          end
        end
      end
      default: seq_d = SEQ_IDLE;
    endcase
  end

  // Sequencer state, byte index and running checksum.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      seq_q <= SEQ_IDLE;
      idx_q <= 4'd0;
      chk_q <= 8'h00;
    end else begin
      seq_q <= seq_d;
      idx_q <= idx_d;
      chk_q <= chk_d;
    end
  end

  // Snapshot capture on accept; later input changes cannot disturb a frame in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ir_q  <= 16'h0;
      pc_q  <= 16'h0;
      acc_q <= 16'h0;
      st_q  <= 9'h0;
      alu_q <= 16'h0;
      op_q  <= 4'h0;
    end else if (accept) begin
      ir_q  <= dbgIr;
      pc_q  <= dbgPc;
      acc_q <= dbgAcc;
      st_q  <= dbgState;
      alu_q <= dbgAluResult;
      op_q  <= dbgAluOp;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .resetN   (resetN),
    .start    (tx_start),
    .data     (load_byte),
    .tx       (uart_tx),
    .byteDone (byte_done),
    .busy     (tx_busy)
  );

  assign busy = (seq_q == SEQ_WAIT_BYTE) | tx_busy;
  assign done = (seq_q == SEQ_FINISH);

endmodule

// File: tb/tb_dbg_snapshot_tx.sv
// tb/tb_dbg_snapshot_tx.sv - randomized self-checking bench with a frame-level reference model
module tb_dbg_snapshot_tx;
  localparam int C = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        send = 1'b0;
  logic [15:0] dbgIr = 16'h0, dbgPc = 16'h0, dbgAcc = 16'h0, dbgAluResult = 16'h0;
  logic [8:0]  dbgState = 9'h0;
  logic [3:0]  dbgAluOp = 4'h0;
  logic        uart_tx, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  dbg_snapshot_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .send         (send),
    .dbgIr        (dbgIr),
    .dbgPc        (dbgPc),
    .dbgAcc       (dbgAcc),
    .dbgState     (dbgState),
    .dbgAluResult (dbgAluResult),
    .dbgAluOp     (dbgAluOp),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is a list of line levels, one entry per cycle.
  typedef struct packed {logic tx; logic busy; logic done;} exp_t;
  exp_t       eq[$];
  exp_t       cur_exp = 3'b100;
  logic [7:0] m_frame [13];

  task automatic model_accept();
    logic [7:0] b [13];
    logic       v;
    b[0]  = 8'hA5;
    b[1]  = dbgIr[15:8];        b[2]  = dbgIr[7:0];
    b[3]  = dbgPc[15:8];        b[4]  = dbgPc[7:0];
    b[5]  = dbgAcc[15:8];       b[6]  = dbgAcc[7:0];
    b[7]  = {7'b0, dbgState[8]}; b[8] = dbgState[7:0];
    b[9]  = dbgAluResult[15:8]; b[10] = dbgAluResult[7:0];
    b[11] = {4'b0, dbgAluOp};
    b[12] = 8'h00;
    for (int i = 1; i <= 11; i++) b[12] = b[12] ^ b[i];
    m_frame = b;
    for (int i = 0; i < 13; i++)
      for (int k = 0; k < 10; k++) begin
        v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[i][k-1];
        repeat (C) eq.push_back({v, 1'b1, 1'b0});
      end
    eq.push_back(3'b101);
  endtask

  initial forever begin
    @(posedge clk);
    if (!resetN) begin
      eq.delete();
      cur_exp = 3'b100;
    end else begin
      if (send && !cur_exp.busy) model_accept();
      cur_exp = (eq.size() > 0) ? eq.pop_front() : 3'b100;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    exp_t e;
    e = resetN ? cur_exp : 3'b100;
    n_checks++;
    if ({uart_tx, busy, done} !== e) begin
      n_errors++;
      $display("FAIL cycle_outputs t=%0t tx/busy/done got %b%b%b expected %b%b%b",
               $time, uart_tx, busy, done, e.tx, e.busy, e.done);
    end
  end

  // Independent UART line decoder sampling mid-bit.
  logic [7:0] rx_q[$];
  logic [7:0] sh;
  logic       in_byte = 1'b0;
  int         dc = 0;
  always @(negedge clk) begin
    if (!resetN) in_byte = 1'b0;
    else if (!in_byte) begin
      if (uart_tx === 1'b0) begin in_byte = 1'b1; dc = 0; end
    end else begin
      dc++;
      if ((dc % C) == C/2 && dc/C >= 1 && dc/C <= 8) sh[dc/C-1] = uart_tx;
      if (dc == 9*C + C/2) rx_q.push_back(sh);
      if (dc == 10*C - 1) in_byte = 1'b0;
    end
  end

  logic [7:0] lit [13];

  task automatic send_pulse();
    @(posedge clk); #2 send = 1'b1;
    @(posedge clk); #2 send = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (n < limit && done !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic check_rx_model(input string tag);
    check({tag, "_nbytes"}, rx_q.size(), 13);
    for (int i = 0; i < 13 && i < rx_q.size(); i++) check(tag, rx_q[i], m_frame[i]);
  endtask

  task automatic set_basic();
    dbgIr = 16'h1234; dbgPc = 16'h0005; dbgAcc = 16'hBEEF;
    dbgState = 9'h101; dbgAluResult = 16'h00FF; dbgAluOp = 4'h3;
  endtask

  task automatic set_random();
    dbgIr = 16'($urandom); dbgPc = 16'($urandom); dbgAcc = 16'($urandom);
    dbgState = 9'($urandom); dbgAluResult = 16'($urandom); dbgAluOp = 4'($urandom);
  endtask

  initial begin
    int t0, bad, extra_at;
    lit = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'h05, 8'hBE, 8'hEF,
            8'h01, 8'h01, 8'h00, 8'hFF, 8'h03, 8'h8E};

    // Reset, then 20 idle cycles.
    repeat (3) @(posedge clk);
    #2 resetN = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_after_reset", bad, 0);

    // Basic frame with literal expectations.
    set_basic();
    rx_q.delete();
    send_pulse();
    @(negedge clk);
    check("start_latency", uart_tx, 0);
    t0 = cyc;
    wait_done(600);
    check("done_delay", cyc - t0, 130*C);
    check("basic_nbytes", rx_q.size(), 13);
    for (int i = 0; i < 13 && i < rx_q.size(); i++) check("basic_byte", rx_q[i], lit[i]);
    for (int i = 0; i < 13; i++) check("model_pin", m_frame[i], lit[i]);

    // Snapshot hold: inputs change during byte 3.
    rx_q.delete();
    send_pulse();
    repeat (3*10*C + 10) @(negedge clk);
    dbgIr = 16'hFFFF; dbgPc = 16'hFFFF; dbgAcc = 16'hFFFF;
    dbgState = 9'h1FF; dbgAluResult = 16'hFFFF; dbgAluOp = 4'hF;
    wait_done(600);
    check("hold_nbytes", rx_q.size(), 13);
    for (int i = 0; i < 13 && i < rx_q.size(); i++) check("hold_byte", rx_q[i], lit[i]);

    // Send while busy is ignored.
    set_random();
    rx_q.delete();
    @(posedge clk); #2 done_cnt = 0;
    send_pulse();
    repeat (48) @(posedge clk);
    #2 send = 1'b1; @(posedge clk); #2 send = 1'b0;
    repeat (249) @(posedge clk);
    #2 send = 1'b1; @(posedge clk); #2 send = 1'b0;
    repeat (400) @(posedge clk);
    check("busy_send_done_count", done_cnt, 1);
    check_rx_model("busy_send_byte");

    // Continuous send: two frames one idle cycle apart.
    set_basic();
    rx_q.delete();
    @(posedge clk); #2 send = 1'b1;
    wait_done(600);
    check("gap_idle_high", uart_tx, 1);
    @(posedge clk); #2 send = 1'b0;
    @(negedge clk);
    check("gap_next_start", uart_tx, 0);
    wait_done(600);
    check("cont_nbytes", rx_q.size(), 26);
    for (int i = 0; i < 26 && i < rx_q.size(); i++) check("cont_byte", rx_q[i], lit[i % 13]);

    // Reset during byte 6 data bits.
    set_random();
    send_pulse();
    repeat (250) @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    check("reset_tx_high", uart_tx, 1);
    check("reset_busy_low", busy, 0);
    done_cnt = 0;
    repeat (3) @(posedge clk);
    #2 resetN = 1'b1;
    repeat (20) @(posedge clk);
    check("reset_no_done", done_cnt, 0);
    set_random();
    rx_q.delete();
    send_pulse();
    wait_done(600);
    check_rx_model("after_reset_byte");

    // Randomized frames with stray sends while busy.
    for (int r = 0; r < 5; r++) begin
      set_random();
      rx_q.delete();
      send_pulse();
      extra_at = $urandom_range(10, 400);
      repeat (extra_at) @(posedge clk);
      #2 send = 1'($urandom);
      @(posedge clk); #2 send = 1'b0;
      wait_done(600);
      check_rx_model("rand_byte");
      repeat ($urandom_range(1, 5)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
